// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC frame packer: FSM states, header layout and widths.
package adc_pkt_pkg;

    localparam int unsigned PKT_DATA_W = 64;
    localparam int unsigned PKT_LEN_W  = 16;
    localparam int unsigned PKT_SEQ_W  = 32;
    localparam int unsigned FIFO_W     = 72;

    localparam logic [15:0] PKT_HDR_MAGIC = 16'hADC0;

    // Header layout: magic [63:48], len [47:32], seq [31:0]
    localparam int unsigned HDR_MAGIC_LSB = 48;
    localparam int unsigned HDR_MAGIC_W   = 16;
    localparam int unsigned HDR_LEN_LSB   = 32;
    localparam int unsigned HDR_LEN_W     = 16;
    localparam int unsigned HDR_SEQ_LSB   = 0;
    localparam int unsigned HDR_SEQ_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } pkt_state_t;

    function automatic logic [PKT_DATA_W-1:0] make_header(
        input logic [HDR_MAGIC_W-1:0] magic,
        input logic [HDR_LEN_W-1:0]   len,
        input logic [HDR_SEQ_W-1:0]   seq
    );
        logic [PKT_DATA_W-1:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
        h[HDR_LEN_LSB   +: HDR_LEN_W]   = len;
        h[HDR_SEQ_LSB   +: HDR_SEQ_W]   = seq;
        return h;
    endfunction

endpackage

// File: rtl/adc_pkt_csum.sv
// Modular payload sum for the frame trailer; only built when FRAME_CHECKSUM_EN is defined.
`ifdef FRAME_CHECKSUM_EN
module adc_pkt_csum
    import adc_pkt_pkg::*;
#(
    parameter int unsigned DATA_W = PKT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (acc_en) begin
            sum_q <= sum_q + din;
        end
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/adc_frame_packer.sv
// Drains the FWFT capture FIFO into framed header+payload packets on a valid/ready stream.
// Optional FRAME_CHECKSUM_EN appends a trailer word carrying the modular payload sum.
module adc_frame_packer
    import adc_pkt_pkg::*;
#(
    parameter int unsigned DATA_W    = PKT_DATA_W,
    parameter int unsigned LEN_W     = PKT_LEN_W,
    parameter int unsigned SEQ_W     = PKT_SEQ_W,
    parameter logic [15:0] HDR_MAGIC = PKT_HDR_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_enable,
    input  logic [LEN_W-1:0]  cfg_frame_words,
    input  logic [FIFO_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              user_int,
    output logic [SEQ_W-1:0]  frame_seq,
    output logic              busy
);

    pkt_state_t        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [SEQ_W-1:0]  seq_q;
    logic              int_q;

    logic              xfer;
    logic              last_payload;
    logic              frame_done;
    logic [DATA_W-1:0] hdr_word;
    logic              unused_fifo_hi;

    assign unused_fifo_hi = ^fifo_dout[FIFO_W-1:DATA_W];

    assign xfer         = tx_valid & tx_ready;
    assign last_payload = (cnt_q == len_q - LEN_W'(1));
    assign hdr_word     = DATA_W'(make_header(HDR_MAGIC, len_q[HDR_LEN_W-1:0], seq_q[HDR_SEQ_W-1:0]));

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    adc_pkt_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_HEADER),
        .acc_en (xfer && state == ST_PAYLOAD),
        .din    (fifo_dout[DATA_W-1:0]),
        .sum    (csum)
    );

    assign frame_done = xfer && state == ST_TRAILER;
`else
    assign frame_done = xfer && state == ST_PAYLOAD && last_payload;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            len_q <= '0;
            cnt_q <= '0;
            seq_q <= '0;
            int_q <= 1'b0;
        end else begin
            int_q <= frame_done;
            if (frame_done) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        len_q <= (cfg_frame_words == '0) ? LEN_W'(1) : cfg_frame_words;
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        cnt_q <= '0;
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_payload) begin
`ifdef FRAME_CHECKSUM_EN
                            state <= ST_TRAILER;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                ST_TRAILER: begin
                    if (xfer) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload words pass straight from the FWFT head so there is no extra latency or skid buffer.
    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        case (state)
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = hdr_word;
            end
            ST_PAYLOAD: begin
                tx_valid = !fifo_empty;
                tx_data  = fifo_dout[DATA_W-1:0];
`ifndef FRAME_CHECKSUM_EN
                tx_last  = last_payload;
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            ST_TRAILER: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                tx_last  = 1'b1;
            end
`endif
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign fifo_rd_en = (state == ST_PAYLOAD) && !fifo_empty && tx_ready;
    assign user_int   = int_q;
    assign frame_seq  = seq_q;
    assign busy       = (state != ST_IDLE);

endmodule
